// File: rtl/fifo_wr_arbiter.sv
// Round-robin scheduler sharing one async-FIFO write port among NREQ requesters.
// Grants bursts of up to BURST words, throttles on the FIFO flags, and registers winc/wdata.
module fifo_wr_arbiter #(
    parameter int NREQ  = 4,
    parameter int DSIZE = 8,
    parameter int BURST = 4
) (
    input  logic                  wclk,
    input  logic                  wrst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*DSIZE-1:0] req_data,
    input  logic                  wfull,
    input  logic                  walmost_full,
    output logic [NREQ-1:0]       ack,
    output logic [NREQ-1:0]       grant,
    output logic                  winc,
    output logic [DSIZE-1:0]      wdata,
    output logic                  busy,
    output logic [15:0]           wcount
);

    localparam int IW = $clog2(NREQ);
    localparam int CW = $clog2(BURST + 1);

    typedef enum logic [1:0] {S_IDLE, S_BURST, S_STALL} state_t;

    state_t          state, state_nxt;
    logic [IW-1:0]   owner, owner_nxt;
    logic [IW-1:0]   last_owner, last_owner_nxt;
    logic [IW-1:0]   pick;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic            found;
    logic            stall;
    logic [NREQ-1:0] owner_onehot, owner_nxt_onehot;

    assign stall            = wfull | walmost_full;
    assign owner_onehot     = {{(NREQ-1){1'b0}}, 1'b1} << owner;
    assign owner_nxt_onehot = {{(NREQ-1){1'b0}}, 1'b1} << owner_nxt;

    // Cyclic search starting just after the previous owner.
    always_comb begin
        int idx;
        idx   = 0;
        found = 1'b0;
        pick  = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(last_owner) + k) % NREQ;
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = IW'(idx);
            end
        end
    end

    always_comb begin
        state_nxt      = state;
        owner_nxt      = owner;
        last_owner_nxt = last_owner;
        cnt_nxt        = cnt;
        ack            = '0;
        case (state)
            S_IDLE: begin
                if (found) begin
                    owner_nxt = pick;
                    cnt_nxt   = '0;
                    state_nxt = S_BURST;
                end
            end
            S_BURST, S_STALL: begin
                if (stall) begin
                    state_nxt = S_STALL;
                end else if (req[owner]) begin
                    ack       = wrst ? '0 : owner_onehot;
                    cnt_nxt   = cnt + 1'b1;
                    state_nxt = S_BURST;
                    if (cnt_nxt == CW'(BURST)) begin
                        last_owner_nxt = owner;
                        state_nxt      = S_IDLE;
                    end
                end else if (state == S_BURST) begin
                    last_owner_nxt = owner;
                    state_nxt      = S_IDLE;
                end else begin
                    // An owner that vanished during a stall is released by BURST next cycle.
                    state_nxt = S_BURST;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge wclk) begin
        if (wrst) begin
            state      <= S_IDLE;
            owner      <= '0;
            last_owner <= IW'(NREQ - 1);
            cnt        <= '0;
            grant      <= '0;
            busy       <= 1'b0;
        end else begin
            state      <= state_nxt;
            owner      <= owner_nxt;
            last_owner <= last_owner_nxt;
            cnt        <= cnt_nxt;
            grant      <= (state_nxt != S_IDLE) ? owner_nxt_onehot : '0;
            busy       <= (state_nxt != S_IDLE);
        end
    end

    always_ff @(posedge wclk) begin
        if (wrst) begin
            winc   <= 1'b0;
            wdata  <= '0;
            wcount <= '0;
        end else begin
            winc <= |ack;
            if (|ack) begin
                wdata  <= req_data[int'(owner)*DSIZE +: DSIZE];
                wcount <= wcount + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: cycle tables, rotation, drop, FIFO composition, reset.
module tb_fifo_wr_arbiter;

    localparam int NREQ  = 4;
    localparam int DSIZE = 8;
    localparam int BURST = 4;

    logic                  wclk = 1'b0;
    logic                  wrst = 1'b0;
    logic [NREQ-1:0]       req = '0;
    logic [NREQ*DSIZE-1:0] req_data = '0;
    logic                  wfull = 1'b0;
    logic                  walmost_full = 1'b0;
    logic [NREQ-1:0]       ack;
    logic [NREQ-1:0]       grant;
    logic                  winc;
    logic [DSIZE-1:0]      wdata;
    logic                  busy;
    logic [15:0]           wcount;

    fifo_wr_arbiter #(.NREQ(NREQ), .DSIZE(DSIZE), .BURST(BURST)) dut (
        .wclk(wclk), .wrst(wrst), .req(req), .req_data(req_data),
        .wfull(wfull), .walmost_full(walmost_full), .ack(ack), .grant(grant),
        .winc(winc), .wdata(wdata), .busy(busy), .wcount(wcount)
    );

    always #5 wclk = ~wclk;

    typedef struct {
        bit         rst;
        logic [7:0] base;
        int         len;
        bit         alm;
        logic [3:0] eack;
        logic [3:0] egrant;
        bit         ewinc;
        bit         ebusy;
        int         ewc;
    } vec_t;

    int         checks = 0;
    int         failures = 0;
    logic [7:0] sb[$];
    logic [7:0] exp_rd[$];
    logic [7:0] fifoq[$];
    logic [7:0] rbase[NREQ];
    int         ridx[NREQ];
    int         rlen[NREQ];
    bit         fifo_mode = 1'b0;
    bit         fifo_read = 1'b0;
    int         rd_got = 0;
    logic [3:0] s_ack, s_grant, s_req;
    logic       s_winc, s_busy;
    logic [15:0] s_wc;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic updateReq();
        for (int i = 0; i < NREQ; i++) begin
            req[i] = (ridx[i] < rlen[i]);
            req_data[i*DSIZE +: DSIZE] = rbase[i] + 8'(ridx[i]);
        end
    endtask

    task automatic loadReq(input int i, input logic [7:0] base, input int len);
        rbase[i] = base;
        ridx[i]  = 0;
        rlen[i]  = len;
        updateReq();
    endtask

    task automatic runCycle(input bit rstchk);
        logic [3:0] a;
        logic       pw;
        logic [7:0] pd;
        logic [7:0] d;
        @(negedge wclk);
        a = ack;
        s_ack = ack; s_grant = grant; s_winc = winc; s_busy = busy; s_wc = wcount; s_req = req;
        checkOutput("ack_onehot", 32'($countones(a) <= 1), 1);
        if (wrst) checkOutput("ack_in_reset", a, 0);
        if (fifo_mode && winc) checkOutput("winc_while_full", wfull, 0);
        pw = winc;
        pd = wdata;
        @(posedge wclk);
        #1;
        if (fifo_mode && pw) begin
            checkOutput("fifo_overflow", 32'(fifoq.size() < 16), 1);
            fifoq.push_back(pd);
        end
        if (fifo_mode && fifo_read && fifoq.size() > 0) begin
            d = fifoq.pop_front();
            rd_got++;
            if (exp_rd.size() > 0) checkOutput("fifo_order", d, exp_rd.pop_front());
            else checkOutput("fifo_extra_read", 1, 0);
        end
        if (fifo_mode) begin
            wfull        = (fifoq.size() == 16);
            walmost_full = (fifoq.size() >= 14);
        end
        if (winc) begin
            if (sb.size() == 0) checkOutput("unexpected_winc", wdata, 32'hFFFF_FFFF);
            else checkOutput("wdata", wdata, sb.pop_front());
        end
        if (rstchk) begin
            checkOutput("rst_grant", grant, 0);
            checkOutput("rst_winc", winc, 0);
            checkOutput("rst_busy", busy, 0);
            checkOutput("rst_wcount", wcount, 0);
        end
        for (int i = 0; i < NREQ; i++) if (a[i]) ridx[i]++;
        updateReq();
    endtask

    task automatic doReset();
        fifo_mode    = 1'b0;
        fifo_read    = 1'b0;
        wfull        = 1'b0;
        walmost_full = 1'b0;
        for (int i = 0; i < NREQ; i++) loadReq(i, 8'h00, 0);
        sb.delete();
        wrst = 1'b1;
        runCycle(1);
        wrst = 1'b0;
    endtask

    task automatic applyStimulus(input vec_t v);
        if (v.rst) begin
            doReset();
            loadReq(0, v.base, v.len);
            for (int k = 0; k < v.len; k++) sb.push_back(v.base + 8'(k));
        end else begin
            walmost_full = v.alm;
            runCycle(0);
            checkOutput("tbl_ack", s_ack, v.eack);
            checkOutput("tbl_grant", s_grant, v.egrant);
            checkOutput("tbl_winc", s_winc, v.ewinc);
            checkOutput("tbl_busy", s_busy, v.ebusy);
            if (v.ewc >= 0) checkOutput("tbl_wcount", s_wc, v.ewc);
        end
    endtask

    initial begin
        vec_t tbl[21];
        logic [3:0] gseq[$];
        logic [3:0] prev_g;
        logic [3:0] first_g;
        int gap;
        bit seen, done;

        // single requester burst, then a mid-burst almost-full stall
        tbl[0]  = '{1, 8'h10, 4, 0, 4'h0, 4'h0, 0, 0, -1};
        tbl[1]  = '{0, 8'h00, 0, 0, 4'h0, 4'h0, 0, 0, -1};
        tbl[2]  = '{0, 8'h00, 0, 0, 4'h1, 4'h1, 0, 1, -1};
        tbl[3]  = '{0, 8'h00, 0, 0, 4'h1, 4'h1, 1, 1, -1};
        tbl[4]  = '{0, 8'h00, 0, 0, 4'h1, 4'h1, 1, 1, -1};
        tbl[5]  = '{0, 8'h00, 0, 0, 4'h1, 4'h1, 1, 1, -1};
        tbl[6]  = '{0, 8'h00, 0, 0, 4'h0, 4'h0, 1, 0, -1};
        tbl[7]  = '{0, 8'h00, 0, 0, 4'h0, 4'h0, 0, 0, 4};
        tbl[8]  = '{1, 8'h20, 4, 0, 4'h0, 4'h0, 0, 0, -1};
        tbl[9]  = '{0, 8'h00, 0, 0, 4'h0, 4'h0, 0, 0, -1};
        tbl[10] = '{0, 8'h00, 0, 0, 4'h1, 4'h1, 0, 1, -1};
        tbl[11] = '{0, 8'h00, 0, 0, 4'h1, 4'h1, 1, 1, -1};
        tbl[12] = '{0, 8'h00, 0, 1, 4'h0, 4'h1, 1, 1, -1};
        tbl[13] = '{0, 8'h00, 0, 1, 4'h0, 4'h1, 0, 1, -1};
        tbl[14] = '{0, 8'h00, 0, 1, 4'h0, 4'h1, 0, 1, -1};
        tbl[15] = '{0, 8'h00, 0, 1, 4'h0, 4'h1, 0, 1, -1};
        tbl[16] = '{0, 8'h00, 0, 1, 4'h0, 4'h1, 0, 1, -1};
        tbl[17] = '{0, 8'h00, 0, 0, 4'h1, 4'h1, 0, 1, -1};
        tbl[18] = '{0, 8'h00, 0, 0, 4'h1, 4'h1, 1, 1, -1};
        tbl[19] = '{0, 8'h00, 0, 0, 4'h0, 4'h0, 1, 0, -1};
        tbl[20] = '{0, 8'h00, 0, 0, 4'h0, 4'h0, 0, 0, 4};

        for (int i = 0; i < NREQ; i++) begin
            rbase[i] = 8'h00; ridx[i] = 0; rlen[i] = 0;
        end
        updateReq();

        for (int i = 0; i < 21; i++) applyStimulus(tbl[i]);
        checkOutput("tbl_sb_empty", sb.size(), 0);

        // all four requesting: two full rotations
        doReset();
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < NREQ; i++)
                for (int k = 0; k < BURST; k++)
                    sb.push_back(8'h40 + 8'(16 * i) + 8'(r * BURST + k));
        for (int i = 0; i < NREQ; i++) loadReq(i, 8'h40 + 8'(16 * i), 8);
        prev_g = '0; gap = 0; seen = 0;
        for (int c = 0; c < 200 && sb.size() > 0; c++) begin
            runCycle(0);
            if (s_grant != 0 && prev_g == 0) begin
                gseq.push_back(s_grant);
                if (gseq.size() == 5) checkOutput("rot_wcount16", s_wc, 16);
                seen = 1;
            end
            if (seen && s_grant == 0 && s_req != 0) gap++;
            prev_g = s_grant;
        end
        checkOutput("rot_done", sb.size(), 0);
        checkOutput("rot_grants", gseq.size(), 8);
        for (int k = 0; k < 8 && k < gseq.size(); k++)
            checkOutput("rot_order", gseq[k], 4'b0001 << (k % 4));
        checkOutput("rot_idle_gaps", gap, 7);
        checkOutput("rot_wcount", wcount, 32);

        // owner 2 drops after two words; 3 must beat 0 next
        doReset();
        sb.push_back(8'h80); sb.push_back(8'h81); sb.push_back(8'hA0); sb.push_back(8'h90);
        loadReq(2, 8'h80, 2);
        seen = 0; done = 0; first_g = '0;
        for (int c = 0; c < 20 && !done; c++) begin
            runCycle(0);
            if (s_grant != 0 && !seen) first_g = s_grant;
            if (s_grant != 0) seen = 1;
            else if (seen) done = 1;
        end
        checkOutput("drop_release", done, 1);
        checkOutput("drop_first_owner", first_g, 4'b0100);
        loadReq(0, 8'h90, 1);
        loadReq(3, 8'hA0, 1);
        first_g = '0;
        for (int c = 0; c < 30 && sb.size() > 0; c++) begin
            runCycle(0);
            if (s_grant != 0 && first_g == 0) first_g = s_grant;
        end
        checkOutput("drop_next_owner", first_g, 4'b1000);
        checkOutput("drop_done", sb.size(), 0);

        // two requesters streaming into a 16-deep FIFO with no reader
        doReset();
        fifo_mode = 1'b1;
        fifoq.delete(); exp_rd.delete(); rd_got = 0;
        for (int b = 0; b < 5; b++) begin
            for (int k = 0; k < BURST; k++) begin
                sb.push_back(8'(b * BURST + k)); exp_rd.push_back(8'(b * BURST + k));
            end
            for (int k = 0; k < BURST; k++) begin
                sb.push_back(8'h80 + 8'(b * BURST + k)); exp_rd.push_back(8'h80 + 8'(b * BURST + k));
            end
        end
        loadReq(0, 8'h00, 20);
        loadReq(1, 8'h80, 20);
        for (int c = 0; c < 60; c++) runCycle(0);
        checkOutput("fifo_fill_le16", 32'(fifoq.size() <= 16), 1);
        checkOutput("fifo_fill_ge14", 32'(fifoq.size() >= 14), 1);
        fifo_read = 1'b1;
        for (int c = 0; c < 400 && rd_got < 40; c++) runCycle(0);
        checkOutput("fifo_all_read", rd_got, 40);
        checkOutput("fifo_sb_empty", sb.size(), 0);
        checkOutput("fifo_wcount", wcount, 40);

        // reset in the middle of requester 2's burst
        doReset();
        sb.push_back(8'hC0); sb.push_back(8'hC1);
        loadReq(2, 8'hC0, 8);
        for (int c = 0; c < 3; c++) runCycle(0);
        checkOutput("midrst_pre_grant", grant, 4'b0100);
        wrst = 1'b1;
        runCycle(1);
        wrst = 1'b0;
        sb.push_back(8'hD0);
        loadReq(0, 8'hD0, 1);
        first_g = '0;
        for (int c = 0; c < 20 && sb.size() > 0; c++) begin
            runCycle(0);
            if (s_grant != 0 && first_g == 0) first_g = s_grant;
        end
        checkOutput("midrst_priority", first_g, 4'b0001);
        checkOutput("midrst_done", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
